// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the core's single request/acknowledge memory port between the
// instruction-fetch requester and the load/store requester. Data accesses
// win contention, but after STARVE_MAX consecutive data wins over a waiting
// fetch the fetch is served. A branch redirect (i_if_flush) kills a fetch
// that is pending or already on the bus; the bus transaction still
// completes, but its response is dropped.
//
// Parameters
//   ADDR_W      address width
//   DATA_W      data width
//   STARVE_MAX  consecutive fetch denials before fetch wins (>= 1)
//
// Ports
//   i_clk        core clock, all state changes on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_if_req     fetch request, held with i_if_addr until ack or flush
//   i_if_addr    fetch address
//   i_if_flush   branch redirect, kills a pending or outstanding fetch
//   o_if_ack     one-cycle pulse, o_if_rdata valid in that cycle
//   o_if_rdata   fetched doubleword
//   i_d_req      data request, held with its attributes until ack
//   i_d_we       1 = store, 0 = load
//   i_d_addr     data address
//   i_d_wdata    store data
//   i_d_wmask    store byte mask, passed through unchanged
//   o_d_ack      one-cycle pulse, o_d_rdata valid in that cycle
//   o_d_rdata    raw load data
//   o_mem_req    memory request, held until i_mem_ack
//   o_mem_we     memory write strobe
//   o_mem_addr   memory address
//   o_mem_wdata  memory write data
//   o_mem_wmask  memory write mask
//   i_mem_rdata  memory read data, valid with i_mem_ack
//   i_mem_ack    one-cycle completion pulse
//   o_busy       high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_if_flush,
  output logic              o_if_ack,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  input  logic [7:0]        i_d_wmask,
  output logic              o_d_ack,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [7:0]        o_mem_wmask,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MEM_I = 2'd1;
  localparam logic [1:0] S_MEM_D = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_starveCnt;
  logic              r_kill;
  logic              r_ifAck;
  logic              r_dAck;
  logic [DATA_W-1:0] r_ifRdata;
  logic [DATA_W-1:0] r_dRdata;
  logic              r_memWe;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;
  logic [7:0]        r_memWmask;

  logic w_ifValid;
  logic w_grantD;
  logic w_grantI;
  logic w_killNow;

  // Arbitration decision, only acted upon while idle. A flush in the same
  // cycle hides the fetch request entirely, so a flushed fetch neither wins
  // nor counts as a starved requester. Data wins unless the fetch has
  // already been passed over STARVE_MAX times in a row.
  assign w_ifValid = i_if_req & ~i_if_flush;
  assign w_grantD  = i_d_req & ~(w_ifValid & (r_starveCnt == STARVE_LIMIT));
  assign w_grantI  = w_ifValid & ~w_grantD;

  // The fetch response is dropped if a redirect was seen at any point while
  // the fetch was on the bus, including the cycle the data comes back.
  assign w_killNow = r_kill | i_if_flush;

  // Bus request and busy are decoded straight from the state register, so
  // no input reaches them combinationally.
  assign o_mem_req   = (r_state == S_MEM_I) | (r_state == S_MEM_D);
  assign o_busy      = (r_state != S_IDLE);
  assign o_if_ack    = r_ifAck;
  assign o_d_ack     = r_dAck;
  assign o_if_rdata  = r_ifRdata;
  assign o_d_rdata   = r_dRdata;
  assign o_mem_we    = r_memWe;
  assign o_mem_addr  = r_memAddr;
  assign o_mem_wdata = r_memWdata;
  assign o_mem_wmask = r_memWmask;

  // Main sequencer. IDLE grants and latches the winner's bus attributes,
  // which then stay frozen until the next grant. MEM_x waits for the memory
  // acknowledge and captures read data; the requester's ack register is set
  // on that same edge so the pulse lines up with the RESP cycle. The owner
  // of the response is therefore implied by which ack register was loaded.
  // RESP is a single cycle that returns to IDLE and clears the kill flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_starveCnt <= '0;
      r_kill      <= 1'b0;
      r_ifAck     <= 1'b0;
      r_dAck      <= 1'b0;
      r_ifRdata   <= '0;
      r_dRdata    <= '0;
      r_memWe     <= 1'b0;
      r_memAddr   <= '0;
      r_memWdata  <= '0;
      r_memWmask  <= '0;
    end else begin
      r_ifAck <= 1'b0;
      r_dAck  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grantD) begin
            r_state    <= S_MEM_D;
            r_memWe    <= i_d_we;
            r_memAddr  <= i_d_addr;
            r_memWdata <= i_d_wdata;
            r_memWmask <= i_d_wmask;
            if (w_ifValid && (r_starveCnt != STARVE_LIMIT)) begin
              r_starveCnt <= r_starveCnt + CNT_W'(1);
            end
          end else if (w_grantI) begin
            r_state     <= S_MEM_I;
            r_memWe     <= 1'b0;
            r_memAddr   <= i_if_addr;
            r_memWdata  <= '0;
            r_memWmask  <= '0;
            r_starveCnt <= '0;
          end
        end
        S_MEM_I: begin
          r_kill <= w_killNow;
          if (i_mem_ack) begin
            r_state <= S_RESP;
            if (!w_killNow) begin
              r_ifAck   <= 1'b1;
              r_ifRdata <= i_mem_rdata;
            end
          end
        end
        S_MEM_D: begin
          if (i_mem_ack) begin
            r_state  <= S_RESP;
            r_dAck   <= 1'b1;
            r_dRdata <= i_mem_rdata;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_kill  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter: a table of single transactions,
// hand-written multi-cycle sequences (contention, starvation, flush, flush
// masking, asynchronous reset) and a randomized run checked against a
// transaction-level reference model that schedules grants and responses
// with cycle arithmetic.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW          = 64;
  localparam int DW          = 64;
  localparam int SMAX        = 4;
  localparam int RAND_CYCLES = 3000;

  logic          clk = 1'b0;
  logic          rstN;
  logic          ifReq;
  logic [AW-1:0] ifAddr;
  logic          ifFlush;
  logic          ifAck;
  logic [DW-1:0] ifRdata;
  logic          dReq;
  logic          dWe;
  logic [AW-1:0] dAddr;
  logic [DW-1:0] dWdata;
  logic [7:0]    dWmask;
  logic          dAck;
  logic [DW-1:0] dRdata;
  logic          memReq;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWdata;
  logic [7:0]    memWmask;
  logic [DW-1:0] memRdata;
  logic          memAck;
  logic          busy;

  int nVec  = 0;
  int nMiss = 0;

  typedef struct {
    string       name;
    bit          isData;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    int          lat;
    logic [63:0] rdata;
    bit          expWe;
    logic [7:0]  expMask;
    int          expAckCyc;
  } vec_t;

  vec_t          vecs[6];
  vec_t          v;
  logic [DW-1:0] eIr;
  logic [DW-1:0] eDr;

  // Reference-model and random-requester state
  int            c, cc, nextSample, grantCyc, ackCyc, starve, dCnt, fCnt;
  bit            txnValid, ownerD, killed, vF, grantD, grantF;
  bit            fAct, dAct, fetchAckNow, dataAckNow, expD;
  bit            dW, eWe;
  logic [63:0]   fA, dA, dWd, eAddr, eWdata, mRd;
  logic [7:0]    dM, eMask;

  // Free-running core clock
  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STARVE_MAX(SMAX)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_if_req   (ifReq),
    .i_if_addr  (ifAddr),
    .i_if_flush (ifFlush),
    .o_if_ack   (ifAck),
    .o_if_rdata (ifRdata),
    .i_d_req    (dReq),
    .i_d_we     (dWe),
    .i_d_addr   (dAddr),
    .i_d_wdata  (dWdata),
    .i_d_wmask  (dWmask),
    .o_d_ack    (dAck),
    .o_d_rdata  (dRdata),
    .o_mem_req  (memReq),
    .o_mem_we   (memWe),
    .o_mem_addr (memAddr),
    .o_mem_wdata(memWdata),
    .o_mem_wmask(memWmask),
    .i_mem_rdata(memRdata),
    .i_mem_ack  (memAck),
    .o_busy     (busy)
  );

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One comparison
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive both requester interfaces
  task automatic applyStimulus(input bit f, input logic [63:0] fa, input bit fl,
                               input bit d, input bit we, input logic [63:0] da,
                               input logic [63:0] wd, input logic [7:0] wm);
    ifReq   = f;
    ifAddr  = fa;
    ifFlush = fl;
    dReq    = d;
    dWe     = we;
    dAddr   = da;
    dWdata  = wd;
    dWmask  = wm;
  endtask

  task automatic idleInputs();
    applyStimulus(0, '0, 0, 0, 0, '0, '0, '0);
    memAck   = 1'b0;
    memRdata = '0;
  endtask

  task automatic checkCtl(input string tag, input bit eReq, input bit eBusy, input bit eIfAck, input bit eDAck);
    checkOutput({tag, "/memReq"}, memReq, eReq);
    checkOutput({tag, "/busy"},   busy,   eBusy);
    checkOutput({tag, "/ifAck"},  ifAck,  eIfAck);
    checkOutput({tag, "/dAck"},   dAck,   eDAck);
  endtask

  task automatic checkZero(input string tag);
    checkCtl(tag, 0, 0, 0, 0);
    checkOutput({tag, "/memWe"},    memWe,    0);
    checkOutput({tag, "/memAddr"},  memAddr,  0);
    checkOutput({tag, "/memWdata"}, memWdata, 0);
    checkOutput({tag, "/memWmask"}, memWmask, 0);
    checkOutput({tag, "/ifRdata"},  ifRdata,  0);
    checkOutput({tag, "/dRdata"},   dRdata,   0);
  endtask

  task automatic doReset(input string tag);
    idleInputs();
    rstN = 1'b0;
    tick();
    tick();
    checkZero(tag);
    rstN = 1'b1;
    eIr  = '0;
    eDr  = '0;
    tick();
  endtask

  initial begin
    idleInputs();
    rstN = 1'b0;
    eIr  = '0;
    eDr  = '0;

    vecs[0] = '{"fetch_80000000", 0, 0, 64'h8000_0000, 64'h0, 8'h00, 1, 64'h13, 0, 8'h00, 3};
    vecs[1] = '{"load_80001000", 1, 0, 64'h8000_1000, 64'h0, 8'h00, 0, 64'h1122_3344_5566_7788, 0, 8'h00, 2};
    vecs[2] = '{"store_80002000", 1, 1, 64'h8000_2000, 64'hdead_beef, 8'h08, 2, 64'h5555, 1, 8'h08, 4};
    vecs[3] = '{"fetch_lat0", 0, 0, 64'h8000_0004, 64'h0, 8'h00, 0, 64'h0010_0093, 0, 8'h00, 2};
    vecs[4] = '{"load_mask_ff", 1, 0, 64'h8000_1008, 64'h0, 8'hff, 3, 64'hcafe_f00d, 0, 8'hff, 5};
    vecs[5] = '{"store_top", 1, 1, 64'hffff_ffff_ffff_fff8, 64'hffff_ffff_ffff_ffff, 8'hff, 1, 64'h0, 1, 8'hff, 3};

    doReset("reset");

    // Table of isolated transactions; fetches drive junk on the data bus
    foreach (vecs[i]) begin
      v = vecs[i];
      if (v.isData) applyStimulus(0, '0, 0, 1, v.we, v.addr, v.wdata, v.wmask);
      else          applyStimulus(1, v.addr, 0, 0, 1, '0, '1, 8'hff);
      for (int cyc = 1; cyc <= v.expAckCyc + 1; cyc++) begin
        tick();
        memAck   = (cyc == v.lat + 1);
        memRdata = memAck ? v.rdata : 64'h0bad_0bad_0bad_0bad;
        if (cyc == v.expAckCyc) begin
          if (v.isData) eDr = v.rdata;
          else          eIr = v.rdata;
        end
        checkCtl(v.name, cyc < v.expAckCyc, cyc <= v.expAckCyc,
                 !v.isData && cyc == v.expAckCyc, v.isData && cyc == v.expAckCyc);
        checkOutput({v.name, "/ifRdata"}, ifRdata, eIr);
        checkOutput({v.name, "/dRdata"},  dRdata,  eDr);
        if (cyc <= v.expAckCyc) begin
          checkOutput({v.name, "/memAddr"},  memAddr,  v.addr);
          checkOutput({v.name, "/memWe"},    memWe,    v.expWe);
          checkOutput({v.name, "/memWmask"}, memWmask, v.expMask);
          if (v.isData) checkOutput({v.name, "/memWdata"}, memWdata, v.wdata);
        end
        if (cyc == v.expAckCyc) applyStimulus(0, '0, 0, 0, 0, '0, '0, '0);
      end
    end

    // Contention: data first, fetch served in the following idle cycle
    applyStimulus(1, 64'h8000_0040, 0, 1, 0, 64'h8000_1000, '0, '0);
    tick();
    checkCtl("cont_d", 1, 1, 0, 0);
    checkOutput("cont_d/memAddr", memAddr, 64'h8000_1000);
    memAck = 1; memRdata = 64'haaaa;
    tick();
    memAck = 0;
    checkCtl("cont_dack", 0, 1, 0, 1);
    checkOutput("cont_dack/dRdata", dRdata, 64'haaaa);
    applyStimulus(1, 64'h8000_0040, 0, 0, 0, '0, '0, '0);
    tick();
    checkCtl("cont_idle", 0, 0, 0, 0);
    tick();
    checkCtl("cont_i", 1, 1, 0, 0);
    checkOutput("cont_i/memAddr", memAddr, 64'h8000_0040);
    checkOutput("cont_i/memWe", memWe, 0);
    memAck = 1; memRdata = 64'hbbbb;
    tick();
    idleInputs();
    checkCtl("cont_iack", 0, 1, 1, 0);
    checkOutput("cont_iack/ifRdata", ifRdata, 64'hbbbb);
    eIr = 64'hbbbb;
    eDr = 64'haaaa;
    tick();

    // Starvation: both held continuously; every fifth grant is the fetch
    doReset("reset_starve");
    dCnt = 0;
    fCnt = 0;
    applyStimulus(1, 64'h8000_0100, 0, 1, 0, 64'h8000_3000, '0, '0);
    for (int g = 0; g < 10; g++) begin
      expD = (g % 5) != 4;
      tick();
      checkCtl($sformatf("starve%0d_bus", g), 1, 1, 0, 0);
      checkOutput($sformatf("starve%0d_addr", g), memAddr,
                  expD ? 64'h8000_3000 + 64'(dCnt * 8) : 64'h8000_0100 + 64'(fCnt * 256));
      memAck = 1; memRdata = 64'(g);
      tick();
      memAck = 0;
      checkCtl($sformatf("starve%0d_ack", g), 0, 1, !expD, expD);
      if (expD) begin
        dCnt++;
        dAddr = 64'h8000_3000 + 64'(dCnt * 8);
      end else begin
        fCnt++;
        ifAddr = 64'h8000_0100 + 64'(fCnt * 256);
      end
      tick();
    end
    idleInputs();
    tick();

    // Flush while the fetch is on the bus: completes silently
    eIr = ifRdata == 64'h9 ? 64'h9 : 64'h4;
    applyStimulus(1, 64'h8000_0400, 0, 0, 0, '0, '0, '0);
    tick();
    checkCtl("flush_bus", 1, 1, 0, 0);
    checkOutput("flush_bus/addr", memAddr, 64'h8000_0400);
    applyStimulus(0, '0, 1, 0, 0, '0, '0, '0);
    tick();
    ifFlush = 0;
    checkCtl("flush_w1", 1, 1, 0, 0);
    tick();
    checkCtl("flush_w2", 1, 1, 0, 0);
    tick();
    memAck = 1; memRdata = 64'h0bad;
    checkCtl("flush_w3", 1, 1, 0, 0);
    tick();
    memAck = 0;
    checkCtl("flush_resp", 0, 1, 0, 0);
    checkOutput("flush_resp/ifRdata", ifRdata, eIr);
    applyStimulus(1, 64'h8000_0800, 0, 0, 0, '0, '0, '0);
    tick();
    checkCtl("flush_idle", 0, 0, 0, 0);
    tick();
    checkCtl("flush_new", 1, 1, 0, 0);
    checkOutput("flush_new/addr", memAddr, 64'h8000_0800);
    memAck = 1; memRdata = 64'h77;
    tick();
    idleInputs();
    checkCtl("flush_newack", 0, 1, 1, 0);
    checkOutput("flush_newack/ifRdata", ifRdata, 64'h77);
    tick();

    // A flush in the idle cycle masks a lone fetch request
    applyStimulus(1, 64'h8000_0c00, 1, 0, 0, '0, '0, '0);
    tick();
    idleInputs();
    checkCtl("flush_mask", 0, 0, 0, 0);
    tick();

    // Reset in the middle of a store clears everything at once
    applyStimulus(0, '0, 0, 1, 1, 64'h8000_5000, 64'h1234, 8'h0f);
    tick();
    checkCtl("rstmid_bus", 1, 1, 0, 0);
    #2;
    rstN = 0;
    #1;
    checkZero("rstmid_async");
    idleInputs();
    tick();
    rstN   = 1;
    memAck = 1;
    tick();
    memAck = 0;
    checkZero("rstmid_lateack");
    tick();
    checkCtl("rstmid_after", 0, 0, 0, 0);

    // Randomized traffic against the transaction-level model
    doReset("reset_rand");
    txnValid = 0; nextSample = 0; starve = 0; killed = 0; ownerD = 0;
    grantCyc = 0; ackCyc = 0;
    eAddr = '0; eWdata = '0; eWe = 0; eMask = '0;
    fAct = 0; dAct = 0; fA = '0; dA = '0; dWd = '0; dW = 0; dM = '0;
    for (c = 0; c < RAND_CYCLES; c++) begin
      fetchAckNow = txnValid && c == ackCyc + 1 && !ownerD && !killed;
      dataAckNow  = txnValid && c == ackCyc + 1 && ownerD;
      if (fAct && fetchAckNow) fAct = 0;
      if (!fAct && $urandom_range(0, 1) == 1) begin
        fAct = 1;
        fA   = {$urandom, $urandom};
      end
      if (dAct && dataAckNow) dAct = 0;
      if (!dAct && $urandom_range(0, 9) < 7) begin
        dAct = 1;
        dW   = 1'($urandom_range(0, 1));
        dA   = {$urandom, $urandom};
        dWd  = {$urandom, $urandom};
        dM   = 8'($urandom_range(0, 255));
      end
      applyStimulus(fAct, fA, $urandom_range(0, 7) == 0, dAct, dW, dA, dWd, dM);
      if (ifFlush) fAct = 0;
      mRd      = {$urandom, $urandom};
      memAck   = txnValid && c == ackCyc;
      memRdata = mRd;

      if (c == nextSample) begin
        vF     = ifReq && !ifFlush;
        grantD = dReq && !(vF && starve == SMAX);
        grantF = vF && !grantD;
        if (grantD && vF) starve = (starve < SMAX) ? starve + 1 : SMAX;
        if (grantF) starve = 0;
        if (grantD || grantF) begin
          txnValid   = 1;
          ownerD     = grantD;
          killed     = 0;
          grantCyc   = c;
          ackCyc     = c + 1 + $urandom_range(0, 3);
          nextSample = ackCyc + 2;
          eAddr      = grantD ? dAddr : ifAddr;
          eWe        = grantD ? dWe : 1'b0;
          eMask      = grantD ? dWmask : 8'h00;
          eWdata     = dWdata;
        end else begin
          nextSample = c + 1;
        end
      end else if (txnValid && c > grantCyc && c <= ackCyc && !ownerD && ifFlush) begin
        killed = 1;
      end
      if (txnValid && c == ackCyc) begin
        if (ownerD)       eDr = mRd;
        else if (!killed) eIr = mRd;
      end

      tick();
      cc = c + 1;
      checkCtl("rand",
               txnValid && cc > grantCyc && cc <= ackCyc,
               txnValid && cc > grantCyc && cc <= ackCyc + 1,
               txnValid && cc == ackCyc + 1 && !ownerD && !killed,
               txnValid && cc == ackCyc + 1 && ownerD);
      checkOutput("rand/memAddr",  memAddr,  eAddr);
      checkOutput("rand/memWe",    memWe,    eWe);
      checkOutput("rand/memWmask", memWmask, eMask);
      checkOutput("rand/ifRdata",  ifRdata,  eIr);
      checkOutput("rand/dRdata",   dRdata,   eDr);
      if (txnValid && ownerD) checkOutput("rand/memWdata", memWdata, eWdata);
    end
    idleInputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
